mtm_alu_deserializer: RTL and testbench
=======================================

Name: mtm_alu_deserializer

Overview:
- Serial receive front end of the mtm_Alu datapath. Samples the `sin` line one bit per clock and assembles 11-bit frames into a packet: 8 data bytes (B then A) plus 1 command byte.
- Checks packet length, CRC4 and opcode.
- Hands {A, B, op, err_flags} to the ALU core through a one-entry valid/ready output register.

Parameters:
- N_DATA_BYTES, 8, data bytes required before a CMD byte (B[31:24]..B[7:0], then A[31:24]..A[7:0]).
- CRC_INIT, 4'h0, initial value of the CRC4 LFSR at each packet start.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst  in  1  synchronous reset, active-high.
- sin  in  1  serial input; idle high; one bit per clk.
- out_valid  out  1  packet result held in output register.
- out_ready  in  1  core accepts result when out_valid && out_ready.
- A  out  32  operand A.
- B  out  32  operand B.
- op  out  3  opcode field of CMD byte (AND=000, OR=001, ADD=100, SUB=101, RST_OP=010).
- err_flags  out  3  {ERR_DATA, ERR_CRC, ERR_OP}, i.e. 100 / 010 / 001; 000 = no error.
- ovf  out  1  one-cycle pulse: completed packet dropped because the output register was full.

Behaviour:
- Reset: out_valid=0, A=0, B=0, op=0, err_flags=0, ovf=0. Byte count=0, CRC=CRC_INIT, FSM=IDLE. Reset mid-frame or mid-packet discards all partial state.
- Frame format, 11 bits, MSB first: start(0), type (0=DATA, 1=CMD), d[7:0], stop(1).
- FSM states: IDLE, TYPE, BITS, STOP.
  - IDLE: sin==0 -> TYPE.
  - TYPE: latch type -> BITS.
  - BITS: shift 8 bits, then -> STOP.
  - STOP: sin==1 -> process byte, then -> IDLE. sin==0 -> framing error: discard the entire packet (count=0, CRC reset, no output), then -> IDLE.
- A new start bit is accepted in IDLE the cycle after STOP, so back-to-back frames are supported.
- DATA byte processing:
  - Shift into a 64-bit {B,A} register.
  - Feed its 8 bits into the CRC.
  - Increment count, saturating at N_DATA_BYTES+1.
- CMD byte layout: {0, op[2:0], crc[3:0]}.
- CRC4:
  - Polynomial x^4+x+1.
  - Serial update per bit: fb = crc[3]^d; crc = {crc[2:0],0} ^ (fb ? 4'b0011 : 0).
  - Input bit sequence: B[31:0], A[31:0], 1'b1, op[2:0]; 68 bits total, MSB first.
- Error evaluation at CMD stop bit. Only the highest-priority flag is set:
  - count != N_DATA_BYTES -> ERR_DATA.
  - else received crc != computed -> ERR_CRC.
  - else op not in {000,001,100,101,010} -> ERR_OP.
- Result load:
  - Load into the output register the cycle after the CMD stop bit; out_valid rises the next clock. Latency from stop-bit sample to out_valid = 1 cycle.
  - On an error packet, A/B/op carry the received values.
- After any CMD byte: count=0, CRC=CRC_INIT.
- Output handshake:
  - out_valid and data stay stable until out_valid && out_ready.
  - out_valid falls the cycle after acceptance unless a new result loads on that same edge (simultaneous accept + load: new result wins, out_valid stays 1).
  - Result completes while out_valid && !out_ready: drop the new result, pulse ovf one cycle, keep held data.
- Excess DATA bytes (count > N_DATA_BYTES) continue shifting; the older bytes fall out, and ERR_DATA is reported at CMD.
- RST_OP (010) passes through with err_flags=000; the core acts on it.

Test Plan:
- B=32'h2, A=32'h1, CMD byte 8'h4C (ADD, crc=4'hC), out_ready=1 -> out_valid one cycle after CMD stop; A=1, B=2, op=100, err_flags=000.
- Same packet with CMD 8'h4D (crc wrong) -> err_flags=010, op=100.
- 7 DATA bytes then CMD 8'h4C -> err_flags=100. Next valid packet decodes clean (count reset).
- Valid CRC but op=011 -> err_flags=001.
- Stop bit forced 0 on data byte 3, then full valid packet -> no output for the first packet; second packet yields err_flags=000.
- out_ready=0, two back-to-back valid packets -> first held stable, ovf pulses once at second completion; then out_ready=1 -> first accepted, out_valid=0 next cycle.
- rst asserted during byte 5 -> all outputs 0; subsequent packet decodes normally.

Source files
------------

// File: rtl/mtm_alu_deserializer.sv
// mtm_alu_deserializer: serial frame receiver assembling {B,A,op} packets with CRC4/length/opcode checks
module mtm_alu_deserializer #(
  parameter int         N_DATA_BYTES = 8,
  parameter logic [3:0] CRC_INIT     = 4'h0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        sin,
  input  logic        out_ready,
  output logic        out_valid,
  output logic [31:0] A,
  output logic [31:0] B,
  output logic [2:0]  op,
  output logic [2:0]  err_flags,
  output logic        ovf
);
  localparam int CW = $clog2(N_DATA_BYTES + 2);
  typedef enum logic [1:0] {IDLE, TYPE, BITS, STOP} state_t;
  state_t         state_q, state_d;
  logic [2:0]     bit_q, bit_d;
  logic           type_q, type_d;
  logic [7:0]     byte_q, byte_d;
  logic [63:0]    ba_q, ba_d;
  logic [3:0]     crc_q, crc_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic           pend_q, pend_d;
  logic [2:0]     pop_q, pop_d, perr_q, perr_d;
  logic           ov_q, ovf_q;
  logic [31:0]    a_q, b_q;
  logic [2:0]     op_q, err_q;
  logic [3:0]     crc_cmd;
  logic           op_ok;

  function automatic logic [3:0] crc_bit(input logic [3:0] c, input logic d);
    return {c[2:0], 1'b0} ^ ((c[3] ^ d) ? 4'b0011 : 4'b0000);
  endfunction

  function automatic logic [3:0] crc_byte(input logic [3:0] c, input logic [7:0] d);
    logic [3:0] r;
    r = c;
    for (int i = 0; i < 8; i++) r = crc_bit(r, d[7-i]);
    return r;
  endfunction

  function automatic logic [3:0] crc_nib(input logic [3:0] c, input logic [3:0] d);
    logic [3:0] r;
    r = c;
    for (int i = 0; i < 4; i++) r = crc_bit(r, d[3-i]);
    return r;
  endfunction

  // The CMD byte's own contribution to the CRC is a constant 1 followed by the opcode.
  assign crc_cmd = crc_nib(crc_q, {1'b1, byte_q[6:4]});
  assign op_ok   = !(byte_q[6:4] == 3'b011 || byte_q[6:5] == 2'b11);

  always_comb begin
    state_d = state_q;
    bit_d   = bit_q;
    type_d  = type_q;
    byte_d  = byte_q;
    ba_d    = ba_q;
    crc_d   = crc_q;
    cnt_d   = cnt_q;
    pend_d  = 1'b0;
    pop_d   = pop_q;
    perr_d  = perr_q;
    case (state_q)
      IDLE: state_d = sin ? IDLE : TYPE;
      TYPE: begin
        type_d  = sin;
        bit_d   = 3'd0;
        state_d = BITS;
      end
      BITS: begin
        byte_d  = {byte_q[6:0], sin};
        bit_d   = bit_q + 3'd1;
        state_d = (bit_q == 3'd7) ? STOP : BITS;
      end
      default: begin
        state_d = IDLE;
        if (!sin) begin
          cnt_d = '0;
          crc_d = CRC_INIT;
        end else if (!type_q) begin
          ba_d  = {ba_q[55:0], byte_q};
          crc_d = crc_byte(crc_q, byte_q);
          cnt_d = (cnt_q == CW'(N_DATA_BYTES + 1)) ? cnt_q : cnt_q + CW'(1);
        end else begin
          pend_d = 1'b1;
          pop_d  = byte_q[6:4];
          perr_d = (cnt_q != CW'(N_DATA_BYTES)) ? 3'b100 :
                   (byte_q[3:0] != crc_cmd)     ? 3'b010 :
                   !op_ok                       ? 3'b001 : 3'b000;
          cnt_d  = '0;
          crc_d  = CRC_INIT;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      bit_q   <= '0;
      type_q  <= 1'b0;
      byte_q  <= '0;
      ba_q    <= '0;
      crc_q   <= CRC_INIT;
      cnt_q   <= '0;
      pend_q  <= 1'b0;
      pop_q   <= '0;
      perr_q  <= '0;
      ov_q    <= 1'b0;
      ovf_q   <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      op_q    <= '0;
      err_q   <= '0;
    end else begin
      state_q <= state_d;
      bit_q   <= bit_d;
      type_q  <= type_d;
      byte_q  <= byte_d;
      ba_q    <= ba_d;
      crc_q   <= crc_d;
      cnt_q   <= cnt_d;
      pend_q  <= pend_d;
      pop_q   <= pop_d;
      perr_q  <= perr_d;
      ovf_q   <= pend_q && ov_q && !out_ready;
      // ba_q cannot change before the pending result loads: the next data byte is >= 11 cycles away.
      if (pend_q && (!ov_q || out_ready)) begin
        ov_q  <= 1'b1;
        a_q   <= ba_q[31:0];
        b_q   <= ba_q[63:32];
        op_q  <= pop_q;
        err_q <= perr_q;
      end else if (out_ready) begin
        ov_q  <= 1'b0;
      end
    end
  end

  assign out_valid = ov_q;
  assign A         = a_q;
  assign B         = b_q;
  assign op        = op_q;
  assign err_flags = err_q;
  assign ovf       = ovf_q;
endmodule

// File: tb/tb_mtm_alu_deserializer.sv
// tb_mtm_alu_deserializer: directed packets with a queue scoreboard checked by an independent output monitor
module tb_mtm_alu_deserializer;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        sin = 1'b1;
  logic        out_ready = 1'b1;
  logic        out_valid, ovf;
  logic [31:0] A, B;
  logic [2:0]  op, err_flags;

  typedef struct packed {
    logic [31:0] a;
    logic [31:0] b;
    logic [2:0]  op;
    logic [2:0]  err;
  } exp_t;

  exp_t        sb[$];
  int          nvec = 0;
  int          nerr = 0;
  int          ovf_cnt = 0;
  logic [63:0] m_ba = '0;
  logic        held = 1'b0;
  logic [69:0] held_v;

  mtm_alu_deserializer dut (
    .clk(clk), .rst(rst), .sin(sin), .out_ready(out_ready), .out_valid(out_valid),
    .A(A), .B(B), .op(op), .err_flags(err_flags), .ovf(ovf)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic logic [3:0] ref_crc(input logic [31:0] b, input logic [31:0] a, input logic [2:0] o);
    logic [67:0] s;
    logic [3:0]  c;
    logic        fb;
    s = {b, a, 1'b1, o};
    c = 4'h0;
    for (int i = 67; i >= 0; i--) begin
      fb = c[3] ^ s[i];
      c  = {c[2:0], 1'b0} ^ (fb ? 4'b0011 : 4'b0000);
    end
    return c;
  endfunction

  function automatic logic [7:0] mk_cmd(input logic [31:0] b, input logic [31:0] a, input logic [2:0] o);
    return {1'b0, o, ref_crc(b, a, o)};
  endfunction

  task automatic send_bit(input logic b);
    sin = b;
    @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input logic t, input logic [7:0] d, input logic stop);
    send_bit(1'b0);
    send_bit(t);
    for (int i = 7; i >= 0; i--) send_bit(d[i]);
    send_bit(stop);
    sin = 1'b1;
  endtask

  task automatic send_data(input logic [7:0] d);
    send_frame(1'b0, d, 1'b1);
    m_ba = {m_ba[55:0], d};
  endtask

  task automatic send_cmd(input logic [7:0] c, input logic [2:0] err, input bit expect_out);
    if (expect_out) sb.push_back('{a: m_ba[31:0], b: m_ba[63:32], op: c[6:4], err: err});
    send_frame(1'b1, c, 1'b1);
  endtask

  task automatic send_pkt(input logic [31:0] b, input logic [31:0] a, input logic [7:0] c,
                          input logic [2:0] err, input bit expect_out);
    logic [63:0] v;
    v = {b, a};
    for (int i = 0; i < 8; i++) send_data(v[63-8*i -: 8]);
    send_cmd(c, err, expect_out);
  endtask

  task automatic idle(input int n);
    sin = 1'b1;
    repeat (n) @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    if (rst) begin
      held = 1'b0;
    end else begin
      if (ovf) ovf_cnt++;
      if (out_valid) begin
        if (held) chk("hold_stable", 64'({A, B, op, err_flags}), 64'(held_v));
        if (out_ready) begin
          held = 1'b0;
          if (sb.size() == 0) begin
            nvec++;
            nerr++;
            $display("FAIL unexpected_output: got A=%h B=%h op=%b err=%b expected none", A, B, op, err_flags);
          end else begin
            exp_t e;
            e = sb.pop_front();
            chk("A", 64'(A), 64'(e.a));
            chk("B", 64'(B), 64'(e.b));
            chk("op", 64'(op), 64'(e.op));
            chk("err_flags", 64'(err_flags), 64'(e.err));
          end
        end else begin
          held   = 1'b1;
          held_v = {A, B, op, err_flags};
        end
      end else begin
        held = 1'b0;
      end
    end
  end

  initial begin
    int base;
    int t;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_A", 64'(A), 64'd0);
    chk("rst_B", 64'(B), 64'd0);
    chk("rst_op", 64'(op), 64'd0);
    chk("rst_err", 64'(err_flags), 64'd0);
    chk("rst_ovf", 64'(ovf), 64'd0);
    idle(2);

    send_pkt(32'h2, 32'h1, 8'h4C, 3'b000, 1);
    chk("lat_not_yet", 64'(out_valid), 64'd0);
    @(posedge clk);
    #1;
    chk("lat_valid", 64'(out_valid), 64'd1);
    idle(3);

    send_pkt(32'h2, 32'h1, 8'h4D, 3'b010, 1);
    idle(3);

    for (int i = 0; i < 7; i++) send_data((i == 3) ? 8'h02 : 8'h00);
    send_cmd(8'h4C, 3'b100, 1);
    idle(3);
    send_pkt(32'h2, 32'h1, 8'h4C, 3'b000, 1);
    idle(3);

    send_pkt(32'h2, 32'h1, 8'h35, 3'b001, 1);
    idle(3);

    send_data(8'hAA);
    send_data(8'h55);
    send_frame(1'b0, 8'h77, 1'b0);
    send_pkt(32'h2, 32'h1, 8'h4C, 3'b000, 1);
    idle(3);

    send_pkt(32'hDEADBEEF, 32'h12345678, mk_cmd(32'hDEADBEEF, 32'h12345678, 3'b001), 3'b000, 1);
    send_pkt(32'h0000FFFF, 32'hFFFF0000, mk_cmd(32'h0000FFFF, 32'hFFFF0000, 3'b010), 3'b000, 1);
    send_pkt(32'hA5A5A5A5, 32'h5A5A5A5A, mk_cmd(32'hA5A5A5A5, 32'h5A5A5A5A, 3'b000), 3'b000, 1);
    send_data(8'h99);
    send_pkt(32'h11223344, 32'h55667788, mk_cmd(32'h11223344, 32'h55667788, 3'b101), 3'b100, 1);
    idle(3);

    out_ready = 1'b0;
    base = ovf_cnt;
    send_pkt(32'h2, 32'h1, 8'h4C, 3'b000, 1);
    send_pkt(32'h2, 32'h1, 8'h4C, 3'b000, 0);
    idle(3);
    chk("ovf_once", 64'(ovf_cnt - base), 64'd1);
    chk("hold_valid", 64'(out_valid), 64'd1);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    chk("accept_fall", 64'(out_valid), 64'd0);
    idle(2);

    for (int i = 0; i < 4; i++) send_data(8'hC3);
    send_bit(1'b0);
    send_bit(1'b0);
    send_bit(1'b1);
    send_bit(1'b0);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    m_ba = '0;
    chk("mid_rst_valid", 64'(out_valid), 64'd0);
    chk("mid_rst_A", 64'(A), 64'd0);
    chk("mid_rst_B", 64'(B), 64'd0);
    chk("mid_rst_op", 64'(op), 64'd0);
    chk("mid_rst_err", 64'(err_flags), 64'd0);
    chk("mid_rst_ovf", 64'(ovf), 64'd0);
    idle(2);
    send_pkt(32'h2, 32'h1, 8'h4C, 3'b000, 1);

    t = 0;
    while (sb.size() != 0 && t < 200) begin
      @(posedge clk);
      t++;
    end
    #1;
    chk("scoreboard_drained", 64'(sb.size()), 64'd0);
    idle(3);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
